// File: rtl/calc_if.sv
// Operand, control and result bundle for the calc execute stage.
interface calc_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             zx;
  logic             nx;
  logic             zy;
  logic             ny;
  logic             f;
  logic             no;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;

  // Driver side: supplies operands and controls, observes results.
  modport master (
    output x, y, zx, nx, zy, ny, f, no,
    input  out, zr, ng
  );

  // ALU side: consumes operands and controls, produces results.
  modport slave (
    input  x, y, zx, nx, zy, ny, f, no,
    output out, zr, ng
  );
endinterface

// File: rtl/calc.sv
// Registered 16-bit ALU: six-control-bit function on x/y with zero and
// negative flags, one cycle of latency, no stalls.
module calc #(
  parameter int unsigned WIDTH = 16
) (
  input  logic   clk,
  input  logic   rst,
  calc_if.slave  bus
);

  logic [WIDTH-1:0] xa;
  logic [WIDTH-1:0] xb;
  logic [WIDTH-1:0] ya;
  logic [WIDTH-1:0] yb;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] res;

  // Operand conditioning, function select and output inversion.
  // Zeroing is a hard mux so an unknown operand cannot leak through.
  always_comb begin
    xa  = bus.zx ? '0 : bus.x;
    xb  = bus.nx ? ~xa : xa;
    ya  = bus.zy ? '0 : bus.y;
    yb  = bus.ny ? ~ya : ya;
    r   = bus.f ? (xb + yb) : (xb & yb);
    res = bus.no ? ~r : r;
  end

  // Result and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out <= '0;
      bus.zr  <= 1'b1;
      bus.ng  <= 1'b0;
    end else begin
      bus.out <= res;
      bus.zr  <= (res == '0);
      bus.ng  <= res[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_calc.sv
// Self-checking bench for calc: directed corner cases plus randomized
// vectors compared against an arithmetic reference model.
module tb_calc;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  calc_if bus ();

  calc #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Single comparison point: counts every check, reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: {ng, zr, out} from the function rules using integers.
  function automatic logic [17:0] model(input logic [15:0] xi, input logic [15:0] yi,
                                         input logic [5:0] c);
    int xv, yv, rv;
    logic [15:0] o;
    xv = c[5] ? 0 : int'(xi);
    if (c[4]) xv = 65535 - xv;
    yv = c[3] ? 0 : int'(yi);
    if (c[2]) yv = 65535 - yv;
    rv = c[1] ? (xv + yv) % 65536 : (xv & yv);
    if (c[0]) rv = 65535 - rv;
    o = rv[15:0];
    return {rv >= 32768, rv == 0, o};
  endfunction

  task automatic drive(input logic [15:0] xi, input logic [15:0] yi,
                       input logic [5:0] c, input logic r);
    bus.x  = xi;
    bus.y  = yi;
    {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = c;
    rst    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_res(input string tag, input logic [17:0] e);
    check({tag, ".out"}, {16'h0, bus.out}, {16'h0, e[15:0]});
    check({tag, ".zr"},  {31'h0, bus.zr},  {31'h0, e[16]});
    check({tag, ".ng"},  {31'h0, bus.ng},  {31'h0, e[17]});
  endtask

  logic [5:0]  enc [18];
  logic [15:0] rx, ry;
  logic [5:0]  rc;
  logic [17:0] held;

  initial begin
    enc = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
            6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
            6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

    // Reset with arbitrary inputs, then first computed result.
    drive(16'h1234, 16'h5678, 6'b000010, 1'b1);
    check_res("reset", {1'b0, 1'b1, 16'h0000});
    drive(16'h1234, 16'h5678, 6'b000010, 1'b0);
    check_res("post_reset", {1'b0, 1'b0, 16'h68AC});

    // Zeroed x must not propagate unknowns.
    drive('x, 16'h0000, 6'b110111, 1'b0);
    check_res("xmask", {1'b0, 1'b0, 16'h0001});

    // Wrap-around and subtraction.
    drive(16'hFFFF, 16'h0001, 6'b000010, 1'b0);
    check_res("wrap", {1'b0, 1'b1, 16'h0000});
    drive(16'h0003, 16'h0005, 6'b010011, 1'b0);
    check_res("x_minus_y", {1'b1, 1'b0, 16'hFFFE});

    // Logic functions.
    drive(16'h0F0F, 16'h00FF, 6'b000000, 1'b0);
    check_res("and", {1'b0, 1'b0, 16'h000F});
    drive(16'h0F0F, 16'h00FF, 6'b010101, 1'b0);
    check_res("or", {1'b0, 1'b0, 16'h0FFF});

    // Constants and negation.
    drive(16'hABCD, 16'h1357, 6'b111010, 1'b0);
    check_res("minus1", {1'b1, 1'b0, 16'hFFFF});
    drive(16'h0005, 16'h0000, 6'b001111, 1'b0);
    check_res("neg_x", {1'b1, 1'b0, 16'hFFFB});
    drive(16'h0000, 16'h8000, 6'b110011, 1'b0);
    check_res("neg_y", {1'b1, 1'b0, 16'h8000});

    // Every listed encoding on random operands.
    for (int i = 0; i < 18; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      drive(rx, ry, enc[i], 1'b0);
      check_res($sformatf("enc%0d", i), model(rx, ry, enc[i]));
    end

    // Back-to-back random vectors with a reset inserted mid-stream.
    for (int i = 0; i < 40; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rc = 6'($urandom);
      drive(rx, ry, rc, (i == 5));
      if (i == 5) check_res("mid_reset", {1'b0, 1'b1, 16'h0000});
      else        check_res($sformatf("rand%0d", i), model(rx, ry, rc));
    end

    // Raising rst between edges must not disturb the registered result.
    rx = 16'h7FFF;
    ry = 16'h0001;
    drive(rx, ry, 6'b000010, 1'b0);
    held = model(rx, ry, 6'b000010);
    check_res("pre_sync", held);
    #2;
    rst = 1'b1;
    #1;
    check_res("sync_hold", held);
    @(posedge clk);
    #1;
    check_res("sync_reset", {1'b0, 1'b1, 16'h0000});
    drive(rx, ry, 6'b000010, 1'b0);
    check_res("after_sync", held);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/calc.md
Name: calc

Overview:
- 16-bit registered ALU used as the execute stage of the 16-bit pipelined accumulator datapath.
- Computes one of the standard six-control-bit functions (zx, nx, zy, ny, f, no) on operands x and y.
- Registers the result together with zero and negative flags.
- Single cycle of latency, one result per clock, no stalls.

Parameters:
- WIDTH, 16, data width of x, y and out. Only 16 is required; all rules below are written for 16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- x  input  16  operand A.
- y  input  16  operand B.
- zx  input  1  zero x before further processing.
- nx  input  1  bitwise-invert x, applied after zx.
- zy  input  1  zero y before further processing.
- ny  input  1  bitwise-invert y, applied after zy.
- f  input  1  function select: 1 = add, 0 = bitwise AND.
- no  input  1  bitwise-invert the function result.
- out  output  16  registered result.
- zr  output  1  registered flag, 1 when the result is 0x0000.
- ng  output  1  registered flag, equal to bit 15 of the result.

Behaviour:
- Combinational datapath, in order:
  - xa = zx ? 0 : x; xb = nx ? ~xa : xa.
  - ya = zy ? 0 : y; yb = ny ? ~ya : ya.
  - r = f ? (xb + yb) mod 2^16 : (xb & yb).
  - res = no ? ~r : r.
- Addition is 16-bit two's complement. Carry-out is discarded and no overflow flag exists.
- Zeroing is a true multiplexer select. When zx=1, x has no effect even if it is X/Z, and out, zr and ng must be fully defined (0/1 only). The same applies to y with zy.
- Each rising edge with rst=0: out <= res; zr <= (res == 0); ng <= res[15].
- Latency: inputs sampled at edge N appear on out/zr/ng after edge N. No enable; a new result is registered every cycle.
- Each rising edge with rst=1: out <= 0x0000, zr <= 1, ng <= 0. Reset takes priority over any input.
- Reset is synchronous: asserting rst between edges does not change outputs until the next rising edge. After rst deasserts, the first computed result appears after the following edge.
- Before the first clock edge, outputs are undefined. The bench must apply reset or one valid cycle before checking.
- Required function encodings (zx nx zy ny f no -> res):
  - 101010 = 0
  - 111111 = 1
  - 111010 = -1
  - 001100 = x
  - 110000 = y
  - 001101 = ~x
  - 110001 = ~y
  - 001111 = -x
  - 110011 = -y
  - 011111 = x+1
  - 110111 = y+1
  - 001110 = x-1
  - 110010 = y-1
  - 000010 = x+y
  - 010011 = x-y
  - 000111 = y-x
  - 000000 = x&y
  - 010101 = x|y
- Other control combinations follow the datapath equations exactly.

Test Plan:
- Reset: rst=1 for one edge with arbitrary inputs -> out=0x0000, zr=1, ng=0. Drop rst -> next edge shows the computed result.
- X-masking: x=all-X, zx..no=110111, y=0x0000 -> after the edge out=0x0001, zr=0, ng=0, with no X on any output.
- Arithmetic wrap: x=0xFFFF, y=0x0001, 000010 -> out=0x0000, zr=1, ng=0. Then x=0x0003, y=0x0005, 010011 -> out=0xFFFE, zr=0, ng=1.
- Logic: x=0x0F0F, y=0x00FF, 000000 -> out=0x000F. Same operands with 010101 -> out=0x0FFF.
- Constants/negation: 111010 -> out=0xFFFF, ng=1. With x=0x0005, 001111 -> out=0xFFFB. With y=0x8000, 110011 -> out=0x8000, ng=1.
- Pipelining: change inputs every cycle over 8 random vectors -> each output equals the reference model of the previous cycle's inputs. Assert rst mid-stream -> outputs reset on that edge only.
